// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int KEY_W = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {SCAN, DEB, HELD, REL} kp_state_t;

    function automatic logic [IDX_W-1:0] lowest_row(input logic [ROWS-1:0] r);
        logic [IDX_W-1:0] idx;
        logic             found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (r[i] && !found) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    function automatic logic [COLS-1:0] col_onehot(input logic [IDX_W-1:0] idx);
        return COLS'(1) << idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-report bundle between the scanner and its consumer.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [ROWS-1:0]  row;
    logic [COLS-1:0]  col;
    logic [KEY_W-1:0] key;
    logic             key_valid;
    logic             key_held;

    modport master (input row, output col, output key, output key_valid, output key_held);
    modport slave  (output row, input col, input key, input key_valid, input key_held);

endinterface

// File: rtl/keypad_scanner_sync2.sv
// Generic 2-flop synchronizer, cleared to 0 by the active-low reset.
module sync2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         res,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: one-hot column drive, debounced press/release, key code report.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             res,
    keypad_scanner_if.master kp
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    kp_state_t        state;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] rel_cnt;
    logic [IDX_W-1:0] col_idx;
    logic [IDX_W-1:0] cand_row;
    logic [ROWS-1:0]  row_s;
    logic             sample;
    logic             hit;

    sync2 #(.W(ROWS)) u_sync (
        .clk (clk),
        .res (res),
        .d   (kp.row),
        .q   (row_s)
    );

    assign sample = (div_cnt == DIV_LAST);
    assign hit    = row_s[cand_row];

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state        <= SCAN;
            div_cnt      <= '0;
            deb_cnt      <= '0;
            rel_cnt      <= '0;
            col_idx      <= '0;
            cand_row     <= '0;
            kp.col       <= col_onehot('0);
            kp.key       <= '0;
            kp.key_valid <= 1'b0;
            kp.key_held  <= 1'b0;
        end else begin
            kp.key_valid <= 1'b0;
            div_cnt      <= sample ? '0 : div_cnt + DIV_W'(1);
            unique case (state)
                SCAN: begin
                    if (sample) begin
                        if (row_s != '0) begin
                            cand_row <= lowest_row(row_s);
                            // A single required sample means the capture itself is the acceptance.
                            if (DEBOUNCE == 1) begin
                                kp.key       <= {col_idx, lowest_row(row_s)};
                                kp.key_valid <= 1'b1;
                                kp.key_held  <= 1'b1;
                                rel_cnt      <= '0;
                                state        <= HELD;
                            end else begin
                                deb_cnt <= CNT_W'(1);
                                state   <= DEB;
                            end
                        end else begin
                            col_idx <= col_idx + IDX_W'(1);
                            kp.col  <= col_onehot(col_idx + IDX_W'(1));
                        end
                    end
                end
                DEB: begin
                    if (sample) begin
                        if (hit) begin
                            if (deb_cnt == CNT_LAST) begin
                                kp.key       <= {col_idx, cand_row};
                                kp.key_valid <= 1'b1;
                                kp.key_held  <= 1'b1;
                                rel_cnt      <= '0;
                                state        <= HELD;
                            end else begin
                                deb_cnt <= deb_cnt + CNT_W'(1);
                            end
                        end else begin
                            col_idx <= col_idx + IDX_W'(1);
                            kp.col  <= col_onehot(col_idx + IDX_W'(1));
                            state   <= SCAN;
                        end
                    end
                end
                HELD: begin
                    if (sample) begin
                        if (hit) begin
                            rel_cnt <= '0;
                        end else if (rel_cnt == CNT_LAST) begin
                            state <= REL;
                        end else begin
                            rel_cnt <= rel_cnt + CNT_W'(1);
                        end
                    end
                end
                REL: begin
                    kp.key_held <= 1'b0;
                    col_idx     <= col_idx + IDX_W'(1);
                    kp.col      <= col_onehot(col_idx + IDX_W'(1));
                    div_cnt     <= '0;
                    state       <= SCAN;
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule
